instruction_fetch_unit: RTL

- Consumer side of the program-counter interface: turns a sequential fetch address stream into in-order instruction words for decode.
- Issues read requests to instruction memory (valid/ready request channel, in-order response channel with no backpressure).
- Buffers returned words with their PC in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports branch/jump redirect: flushes buffered and in-flight fetches and restarts fetching at a new PC.

---
 rtl/instruction_fetch_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: issues sequential word reads, buffers responses with
// their PC in a small FIFO and hands them to decode; a redirect flushes and restarts.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];

  logic [CW:0] credits_used;
  logic        req_fire;
  logic        rsp_take;
  logic        push;
  logic        pop;

  // Buffered words plus in-flight requests may never exceed the buffer size,
  // so every response is guaranteed a free slot.
  assign credits_used   = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign imem_req_valid = reset & ~redirect_valid & (credits_used < DEPTH_W);
  assign imem_req_addr  = reset ? fetch_pc_reg : RESET_PC;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_take = reset & imem_rsp_valid & (outstanding_reg != '0);
  assign push     = rsp_take & ~redirect_valid & (drop_cnt_reg == '0);

  assign inst_valid = reset & (count_reg != '0) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  assign inst_data  = reset ? inst_mem[rd_ptr_reg] : '0;
  assign inst_pc    = reset ? pc_mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
      inst_mem[wr_ptr_reg] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_take);
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc_reg <= redirect_pc;
        rsp_pc_reg   <= redirect_pc;
        count_reg    <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        drop_cnt_reg <= outstanding_reg - CW'(rsp_take);
      end else begin
        if (req_fire) fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (push) begin
          rsp_pc_reg <= rsp_pc_reg + 32'd4;
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
        if (rsp_take && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - CW'(1);
      end
    end
  end
endmodule
